// File: rtl/gf163_pkg.sv
// Shared constants and FSM encoding for the GF(2^163) multiplier host interface.
package gf163_pkg;

  localparam int unsigned M      = 163;
  localparam int unsigned NWORDS = 6;

  // x^163 = x^7 + x^6 + x^3 + 1
  localparam logic [M-1:0] POLY = 163'hC9;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/gf_mult_io.sv
// Host-side wrapper for an external GF(2^M) multiplier: collects two operands
// from 32-bit host words, runs the multiplier under a watchdog, and streams
// the product back out as 32-bit words.
module gf_mult_io
  import gf163_pkg::NWORDS, gf163_pkg::state_t,
         gf163_pkg::ST_COLLECT, gf163_pkg::ST_RUN, gf163_pkg::ST_DRAIN;
#(
  parameter int unsigned M       = 163,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic [M-1:0]  op_a,
  output logic [M-1:0]  op_b,
  output logic          mult_start,
  input  logic          mult_done,
  input  logic [M-1:0]  mult_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          busy,
  output logic          err
);

  localparam int unsigned AW  = $clog2(M);
  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t         state;
  logic [3:0]     wcnt;
  logic [2:0]     rcnt;
  logic [WDW-1:0] wd;
  logic [M-1:0]   result;

  // Bits of word idx beyond the field width are dropped.
  function automatic logic [M-1:0] put_word(input logic [M-1:0] v,
                                            input logic [2:0]   idx,
                                            input logic [31:0]  w);
    logic [M-1:0] r;
    int unsigned  b;
    r = v;
    for (int unsigned i = 0; i < 32; i++) begin
      b = 32 * 32'(idx) + i;
      if (b < M) r[AW'(b)] = w[i];
    end
    return r;
  endfunction

  // Bits of word idx beyond the field width read as zero.
  function automatic logic [31:0] word_of(input logic [M-1:0] v,
                                          input logic [2:0]   idx);
    logic [31:0] w;
    int unsigned b;
    w = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      b = 32 * 32'(idx) + i;
      if (b < M) w[i] = v[AW'(b)];
    end
    return w;
  endfunction

  // Control FSM: operand collection, watchdog-guarded run, result drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_COLLECT;
      wcnt       <= '0;
      rcnt       <= '0;
      wd         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
      mult_start <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (in_valid && in_ready) begin
            err <= 1'b0;
            if (wcnt < 4'(NWORDS)) op_a <= put_word(op_a, wcnt[2:0], in_data);
            else                   op_b <= put_word(op_b, 3'(wcnt - 4'(NWORDS)), in_data);
            if (wcnt == 4'(2 * NWORDS - 1)) begin
              wcnt       <= '0;
              wd         <= '0;
              mult_start <= 1'b1;
              in_ready   <= 1'b0;
              busy       <= 1'b1;
              state      <= ST_RUN;
            end else begin
              wcnt <= wcnt + 4'd1;
            end
          end
        end
        ST_RUN: begin
          // A completion on the last watchdog cycle still counts as success.
          if (mult_done) begin
            result     <= mult_z;
            out_data   <= word_of(mult_z, 3'd0);
            rcnt       <= '0;
            mult_start <= 1'b0;
            out_valid  <= 1'b1;
            state      <= ST_DRAIN;
          end else if (wd == WDW'(TIMEOUT - 1)) begin
            mult_start <= 1'b0;
            err        <= 1'b1;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
            state      <= ST_COLLECT;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (rcnt == 3'(NWORDS - 1)) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= ST_COLLECT;
            end else begin
              rcnt     <= rcnt + 3'd1;
              out_data <= word_of(result, rcnt + 3'd1);
            end
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: doc/gf_mult_io.md
GF_MULT_IO -- requirements
Module: gf_mult_io

Interface
REQ-001 Parameter M, default 163: field degree, GF(2^M) operand width.
REQ-002 Parameter TIMEOUT, default 255: maximum RUN cycles waiting for mult_done.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  host word valid.
REQ-006 in_ready  out  1  block accepts a host word.
REQ-007 in_data  in  32  host word; 6 words A (LSB word first), then 6 words B.
REQ-008 op_a, op_b  out  M  assembled operands driven to the multiplier.
REQ-009 mult_start  out  1  multiplier request; held high for the whole operation.
REQ-010 mult_done  in  1  multiplier completion, sampled only in RUN.
REQ-011 mult_z  in  M  multiplier product, valid in the cycle mult_done=1.
REQ-012 out_valid  out  1  result word valid.
REQ-013 out_ready  in  1  host accepts a result word.
REQ-014 out_data  out  32  result word, LSB word first.
REQ-015 busy  out  1  high in RUN and DRAIN.
REQ-016 err  out  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be COLLECT, RUN, DRAIN; COLLECT after reset.
REQ-018 COLLECT: in_ready=1; each in_valid&in_ready beat writes in_data into word slot wcnt (0..11), then wcnt increments.
REQ-019 Slots 0-4 / 6-10 fill op_a / op_b bits [32k+31:32k]; slots 5 / 11 use only bits [2:0] -> bits [162:160]; in_data[31:3] of those words is discarded.
REQ-020 On acceptance of slot 11: next cycle state=RUN, mult_start=1 (registered), wcnt=0, in_ready=0.
REQ-021 op_a and op_b SHALL be stable throughout RUN.
REQ-022 RUN: watchdog counter increments each cycle from 0; mult_done=1 captures mult_z into the result register, mult_start=0 and state=DRAIN next cycle.
REQ-023 Watchdog reaching TIMEOUT with mult_done=0: mult_start=0, err=1, state=COLLECT next cycle; result is not produced.
REQ-024 mult_done and timeout in the same cycle: mult_done wins, err unchanged.
REQ-025 DRAIN: out_valid=1, out_data = result word rcnt (0..5); word 5 = {29'b0, z[162:160]}.
REQ-026 rcnt advances only on out_valid&out_ready; out_data SHALL hold while out_ready=0.
REQ-027 Acceptance of word 5: out_valid=0, state=COLLECT, in_ready=1 next cycle.
REQ-028 err SHALL clear on the first accepted host word after it is set.
REQ-029 mult_start SHALL not reassert until a full new 12-word operand set is collected (minimum 1 cycle low between operations).
REQ-030 in_valid is ignored outside COLLECT; mult_done is ignored outside RUN.

Reset
REQ-031 rst=1 SHALL, at the next edge and from any state including mid-RUN/DRAIN: state=COLLECT, wcnt=rcnt=watchdog=0, op_a=op_b=result=0, mult_start=0, out_valid=0, busy=0, err=0; in_ready=1 after rst deasserts.

Structure
REQ-032 Shared package gf163_pkg SHALL hold M=163, NWORDS=6, reduction polynomial constant 163'hC9 (x^163 = x^7+x^6+x^3+1), FSM state encoding.
REQ-033 Single module; no sub-module; the multiplier is instantiated outside, at the top level.

Verification
REQ-034 A=1, B=1 (words 0x1,0,0,0,0,0 each), multiplier model -> mult_start high, result words 0x00000001,0,0,0,0,0.
REQ-035 A word5=0x4 (x^162), B=0x2 -> result word0=0x000000C9, others 0.
REQ-036 A word5=0xFFFFFFF8, others 0 -> op_a=0 during RUN.
REQ-037 out_ready low 10 cycles in DRAIN -> out_data/rcnt frozen, all 6 words delivered exactly once.
REQ-038 mult_done tied 0 -> err=1 and mult_start=0 after 255 RUN cycles; next accepted word clears err.
REQ-039 rst pulsed mid-RUN -> next cycle mult_start=0, busy=0, in_ready=1 after release; fresh operation completes correctly.
